// File: rtl/sam_control_unit.sv
// rtl/sam_control_unit.sv - multi-cycle fetch/decode/execute controller for the Very Half SAM core
module sam_control_unit #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] IReg_Data_Out,
    input  logic [7:0] Acc_Data_Out,
    input  logic       Mem_Ready,
    output logic       IReg_En,
    output logic       PC_En,
    output logic       IAR_En,
    output logic       Acc_En,
    output logic       Mux_PC_Add_Sel,
    output logic       Mux_PC_In_Sel,
    output logic [1:0] Mux_Acc_In_Sel,
    output logic [1:0] ALU_Sel,
    output logic       PC_Buffer_Sel,
    output logic       IReg_Buffer_Sel,
    output logic       IAR_Buffer_Sel,
    output logic       Acc_Buffer_Sel,
    output logic       Mem_Rd,
    output logic       Mem_Wr,
    output logic       Halted,
    output logic       Fault,
    output logic [2:0] State
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_INDIR  = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [3:0]    op;
    logic          mem_op;
    logic          mem_state;
    logic          timed_out;

    assign op        = IReg_Data_Out[7:4];
    assign mem_op    = (op >= 4'h2 && op <= 4'h7) || (op >= 4'hA && op <= 4'hC);
    assign mem_state = (state == S_FETCH) || (state == S_INDIR) || (state == S_EXEC && mem_op);
    assign timed_out = (wait_cnt == CW'(MEM_TIMEOUT - 1));
    assign State     = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            if (mem_state && !Mem_Ready) begin
                if (timed_out)
                    state <= S_FAULT;
                else
                    wait_cnt <= wait_cnt + CW'(1);
            end else begin
                case (state)
                    S_FETCH:  state <= S_DECODE;
                    S_DECODE: begin
                        if (op == 4'hF)
                            state <= S_HALT;
                        else if (op == 4'h0 || op == 4'hD || op == 4'hE)
                            state <= S_FETCH;
                        else
                            state <= S_EXEC;
                    end
                    S_EXEC:   state <= (op == 4'hA || op == 4'hB) ? S_INDIR : S_FETCH;
                    S_INDIR:  state <= S_EXEC2;
                    S_EXEC2:  state <= S_FETCH;
                    S_HALT:   state <= S_HALT;
                    S_FAULT:  state <= S_FAULT;
                    default:  state <= S_FETCH;
                endcase
            end
        end
    end

    // Gating by rst keeps every strobe low for the whole time reset is held.
    always_comb begin
        IReg_En         = 1'b0;
        PC_En           = 1'b0;
        IAR_En          = 1'b0;
        Acc_En          = 1'b0;
        Mux_PC_Add_Sel  = 1'b0;
        Mux_PC_In_Sel   = 1'b0;
        Mux_Acc_In_Sel  = 2'd0;
        ALU_Sel         = 2'd0;
        PC_Buffer_Sel   = 1'b0;
        IReg_Buffer_Sel = 1'b0;
        IAR_Buffer_Sel  = 1'b0;
        Acc_Buffer_Sel  = 1'b0;
        Mem_Rd          = 1'b0;
        Mem_Wr          = 1'b0;
        Halted          = 1'b0;
        Fault           = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    PC_Buffer_Sel = 1'b1;
                    Mem_Rd        = 1'b1;
                    IReg_En       = Mem_Ready;
                end
                S_DECODE: begin
                    PC_En          = 1'b1;
                    Mux_PC_Add_Sel = 1'b1;
                    Mux_PC_In_Sel  = 1'b1;
                end
                S_EXEC: begin
                    case (op)
                        4'h1: begin
                            Acc_En         = 1'b1;
                            Mux_Acc_In_Sel = 2'd1;
                        end
                        4'h2: begin
                            IReg_Buffer_Sel = 1'b1;
                            Mem_Rd          = 1'b1;
                            Mux_Acc_In_Sel  = 2'd2;
                            Acc_En          = Mem_Ready;
                        end
                        4'h3: begin
                            IReg_Buffer_Sel = 1'b1;
                            Acc_Buffer_Sel  = 1'b1;
                            Mem_Wr          = 1'b1;
                        end
                        4'h4, 4'h5, 4'h6, 4'h7: begin
                            IReg_Buffer_Sel = 1'b1;
                            Mem_Rd          = 1'b1;
                            Mux_Acc_In_Sel  = 2'd3;
                            ALU_Sel         = op[1:0];
                            Acc_En          = Mem_Ready;
                        end
                        4'h8: begin
                            PC_En         = 1'b1;
                            Mux_PC_In_Sel = 1'b1;
                        end
                        4'h9: begin
                            PC_En         = (Acc_Data_Out == 8'd0);
                            Mux_PC_In_Sel = 1'b1;
                        end
                        4'hA, 4'hB: begin
                            IReg_Buffer_Sel = 1'b1;
                            Mem_Rd          = 1'b1;
                            IAR_En          = Mem_Ready;
                        end
                        4'hC: begin
                            IReg_Buffer_Sel = 1'b1;
                            Mem_Rd          = 1'b1;
                            PC_En           = Mem_Ready;
                        end
                        default: ;
                    endcase
                end
                S_INDIR: begin
                    IAR_Buffer_Sel = 1'b1;
                    if (op == 4'hA) begin
                        Mem_Rd         = 1'b1;
                        Mux_Acc_In_Sel = 2'd2;
                        Acc_En         = Mem_Ready;
                    end else if (op == 4'hB) begin
                        Mem_Wr         = 1'b1;
                        Acc_Buffer_Sel = 1'b1;
                    end
                end
                S_HALT:  Halted = 1'b1;
                S_FAULT: begin
                    Halted = 1'b1;
                    Fault  = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sam_control_unit.sv
// tb/tb_sam_control_unit.sv - directed bench for sam_control_unit
module tb_sam_control_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] IReg_Data_Out;
    logic [7:0] Acc_Data_Out;
    logic       Mem_Ready;
    logic       IReg_En, PC_En, IAR_En, Acc_En;
    logic       Mux_PC_Add_Sel, Mux_PC_In_Sel;
    logic [1:0] Mux_Acc_In_Sel, ALU_Sel;
    logic       PC_Buffer_Sel, IReg_Buffer_Sel, IAR_Buffer_Sel, Acc_Buffer_Sel;
    logic       Mem_Rd, Mem_Wr, Halted, Fault;
    logic [2:0] State;

    int tests = 0;
    int fails = 0;

    localparam logic [17:0] IREN   = 18'h20000;
    localparam logic [17:0] PCEN   = 18'h10000;
    localparam logic [17:0] IAREN  = 18'h08000;
    localparam logic [17:0] ACCEN  = 18'h04000;
    localparam logic [17:0] ADD1   = 18'h02000;
    localparam logic [17:0] INADD  = 18'h01000;
    localparam logic [17:0] ACCIN1 = 18'h00400;
    localparam logic [17:0] ACCIN2 = 18'h00800;
    localparam logic [17:0] ACCIN3 = 18'h00C00;
    localparam logic [17:0] PCB    = 18'h00080;
    localparam logic [17:0] IRB    = 18'h00040;
    localparam logic [17:0] IARB   = 18'h00020;
    localparam logic [17:0] ACCB   = 18'h00010;
    localparam logic [17:0] RD     = 18'h00008;
    localparam logic [17:0] WR     = 18'h00004;
    localparam logic [17:0] HLTD   = 18'h00002;
    localparam logic [17:0] FLT    = 18'h00001;
    localparam logic [17:0] NONE   = 18'h00000;

    logic [17:0] obs;
    assign obs = {IReg_En, PC_En, IAR_En, Acc_En, Mux_PC_Add_Sel, Mux_PC_In_Sel,
                  Mux_Acc_In_Sel, ALU_Sel, PC_Buffer_Sel, IReg_Buffer_Sel,
                  IAR_Buffer_Sel, Acc_Buffer_Sel, Mem_Rd, Mem_Wr, Halted, Fault};

    sam_control_unit #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .IReg_Data_Out(IReg_Data_Out), .Acc_Data_Out(Acc_Data_Out),
        .Mem_Ready(Mem_Ready), .IReg_En(IReg_En), .PC_En(PC_En), .IAR_En(IAR_En),
        .Acc_En(Acc_En), .Mux_PC_Add_Sel(Mux_PC_Add_Sel), .Mux_PC_In_Sel(Mux_PC_In_Sel),
        .Mux_Acc_In_Sel(Mux_Acc_In_Sel), .ALU_Sel(ALU_Sel), .PC_Buffer_Sel(PC_Buffer_Sel),
        .IReg_Buffer_Sel(IReg_Buffer_Sel), .IAR_Buffer_Sel(IAR_Buffer_Sel),
        .Acc_Buffer_Sel(Acc_Buffer_Sel), .Mem_Rd(Mem_Rd), .Mem_Wr(Mem_Wr),
        .Halted(Halted), .Fault(Fault), .State(State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] st, input logic [17:0] o);
        tests++;
        assert (State === st) else begin
            fails++;
            $error("FAIL %s state: got %0d, want %0d", tag, State, st);
        end
        tests++;
        assert (obs === o) else begin
            fails++;
            $error("FAIL %s outputs: got %05h, want %05h", tag, obs, o);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; Mem_Ready = 1'b1; IReg_Data_Out = 8'h00; Acc_Data_Out = 8'h00;
        repeat (2) @(negedge clk);
        #1 check("reset_held", 3'd0, NONE);

        // LDI 5: three cycles, FETCH -> DECODE -> EXEC -> FETCH
        @(negedge clk); rst = 1'b1; IReg_Data_Out = 8'h15;
        #1 check("ldi_fetch", 3'd0, PCB | RD | IREN);
        next_cycle(); #1 check("ldi_decode", 3'd1, PCEN | ADD1 | INADD);
        next_cycle(); #1 check("ldi_exec", 3'd2, ACCEN | ACCIN1);
        next_cycle(); IReg_Data_Out = 8'h4A;
        #1 check("ldi_back_fetch", 3'd0, PCB | RD | IREN);

        // ADD with Mem_Ready held off three cycles in EXEC
        next_cycle(); Mem_Ready = 1'b0;
        #1 check("add_decode_ignores_ready", 3'd1, PCEN | ADD1 | INADD);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #1 check($sformatf("add_wait%0d", i), 3'd2, IRB | RD | ACCIN3);
        end
        next_cycle(); Mem_Ready = 1'b1;
        #1 check("add_ready", 3'd2, IRB | RD | ACCIN3 | ACCEN);
        next_cycle(); IReg_Data_Out = 8'h93; Acc_Data_Out = 8'h00;
        #1 check("add_back_fetch", 3'd0, PCB | RD | IREN);

        // JZ 3 taken then not taken
        next_cycle(); #1 check("jz0_decode", 3'd1, PCEN | ADD1 | INADD);
        next_cycle(); #1 check("jz0_exec", 3'd2, PCEN | INADD);
        next_cycle(); Acc_Data_Out = 8'h01;
        #1 check("jz1_fetch", 3'd0, PCB | RD | IREN);
        next_cycle(); next_cycle();
        #1 check("jz1_exec", 3'd2, INADD);

        // STIND through INDIR and the turnaround cycle
        next_cycle(); IReg_Data_Out = 8'hB2;
        #1 check("stind_fetch", 3'd0, PCB | RD | IREN);
        next_cycle(); next_cycle();
        #1 check("stind_exec", 3'd2, IRB | RD | IAREN);
        next_cycle(); #1 check("stind_indir", 3'd3, IARB | WR | ACCB);
        next_cycle(); #1 check("stind_exec2", 3'd4, NONE);
        next_cycle(); IReg_Data_Out = 8'hF0;
        #1 check("stind_back_fetch", 3'd0, PCB | RD | IREN);

        // HLT sticks regardless of Mem_Ready
        next_cycle(); next_cycle();
        #1 check("halt", 3'd5, HLTD);
        next_cycle(); #1 check("halt_stays", 3'd5, HLTD);

        // Timeout in FETCH: still waiting after 14 edges, FAULT on the 15th
        rst = 1'b0;
        #1 check("reset_from_halt", 3'd0, NONE);
        @(negedge clk); rst = 1'b1; Mem_Ready = 1'b0;
        #1 check("fetch_wait0", 3'd0, PCB | RD);
        repeat (14) next_cycle();
        #1 check("fetch_wait14", 3'd0, PCB | RD);
        next_cycle(); #1 check("fault", 3'd6, HLTD | FLT);
        Mem_Ready = 1'b1;
        next_cycle(); #1 check("fault_stays", 3'd6, HLTD | FLT);

        // Reset asserted away from a clock edge while LDA waits in EXEC
        rst = 1'b0;
        #1 check("reset_from_fault", 3'd0, NONE);
        @(negedge clk); rst = 1'b1; IReg_Data_Out = 8'h27; Mem_Ready = 1'b1;
        next_cycle(); Mem_Ready = 1'b0;
        next_cycle(); #1 check("lda_wait", 3'd2, IRB | RD | ACCIN2);
        next_cycle(); #2 rst = 1'b0;
        #1 check("async_reset_mid_wait", 3'd0, NONE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sam_control_unit.md
Name: sam_control_unit

Overview:
- Multi-cycle controller for the Very Half SAM core. It sits directly upstream of the datapath and drives every datapath enable, mux select and bus-buffer select.
- It sequences fetch, decode and execute, and handshakes with memory through Mem_Rd/Mem_Wr/Mem_Ready.
- It consumes the datapath's IReg_Data_Out and Acc_Data_Out as instruction and status inputs.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles a memory request may wait for Mem_Ready before the block faults.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- IReg_Data_Out  input  8  instruction from the datapath; opcode = [7:4], operand n = [3:0]
- Acc_Data_Out  input  8  accumulator value, used for the zero test
- Mem_Ready  input  1  memory has completed the current read or write this cycle
- IReg_En, PC_En, IAR_En, Acc_En  output  1 each  register load enables
- Mux_PC_Add_Sel  output  1  1 = add 1, 0 = add target
- Mux_PC_In_Sel  output  1  1 = adder result, 0 = Data_Bus
- Mux_Acc_In_Sel  output  2  3 = ALU, 2 = Data_Bus, 1 = target
- ALU_Sel  output  2  0 = ADD, 1 = SUB, 2 = AND, 3 = OR
- PC_Buffer_Sel, IReg_Buffer_Sel, IAR_Buffer_Sel  output  1 each  address source select; exactly one is high whenever Mem_Rd or Mem_Wr is high
- Acc_Buffer_Sel  output  1  accumulator drives Data_Bus
- Mem_Rd, Mem_Wr  output  1 each  memory request strobes
- Halted  output  1  high in HALT or FAULT
- Fault  output  1  memory timeout occurred
- State  output  3  current state, for debug

Behaviour:
- Reset (rst low, asynchronous): state = FETCH; all outputs 0; wait counter = 0. A reset asserted mid-instruction aborts the instruction immediately; no partial register load is issued.
- Outputs are Moore-decoded from state and IReg_Data_Out, except the load enables inside memory states, which are additionally gated by Mem_Ready.
- Memory handshake:
  - In a memory state, Mem_Rd or Mem_Wr and the address select are held constant until Mem_Ready = 1.
  - The destination enable pulses only in the cycle where Mem_Ready = 1, then the FSM advances.
  - The wait counter increments each cycle without Mem_Ready. Reaching MEM_TIMEOUT moves the FSM to FAULT.
  - Mem_Ready outside a memory state is ignored.
- States: FETCH(0), DECODE(1), EXEC(2), INDIR(3), EXEC2(4), HALT(5), FAULT(6).
- FETCH:
  - PC_Buffer_Sel = 1, Mem_Rd = 1.
  - On Mem_Ready: IReg_En = 1, go to DECODE.
- DECODE:
  - PC_En = 1, Mux_PC_Add_Sel = 1, Mux_PC_In_Sel = 1, so PC <= PC + 1.
  - Next state: HLT goes to HALT, NOP goes to FETCH, otherwise EXEC.
- EXEC, by opcode:
  - 1 LDI: Acc_En = 1, Mux_Acc_In_Sel = 1. One cycle, then FETCH.
  - 2 LDA: IReg_Buffer_Sel = 1, Mem_Rd = 1, Mux_Acc_In_Sel = 2. Acc_En on Mem_Ready, then FETCH.
  - 3 STA: IReg_Buffer_Sel = 1, Acc_Buffer_Sel = 1, Mem_Wr = 1. On Mem_Ready go to FETCH.
  - 4–7 ADD/SUB/AND/OR: as LDA, but Mux_Acc_In_Sel = 3 and ALU_Sel = opcode − 4.
  - 8 JMP: PC_En = 1, Mux_PC_Add_Sel = 0, Mux_PC_In_Sel = 1, so PC <= PC + n (8-bit wrap). One cycle, then FETCH.
  - 9 JZ: as JMP, but PC_En = (Acc_Data_Out == 0). One cycle, then FETCH.
  - A LDIND, B STIND: IReg_Buffer_Sel = 1, Mem_Rd = 1. IAR_En on Mem_Ready, then go to INDIR.
  - C JMPA: IReg_Buffer_Sel = 1, Mem_Rd = 1, Mux_PC_In_Sel = 0. PC_En on Mem_Ready, then FETCH.
  - 0, D, E: treated as NOP (DECODE already routes them to FETCH).
  - F: HLT (DECODE already routes it to HALT).
- INDIR (address from IAR: IAR_Buffer_Sel = 1, others 0):
  - LDIND: Mem_Rd = 1, Mux_Acc_In_Sel = 2, Acc_En on Mem_Ready.
  - STIND: Mem_Wr = 1, Acc_Buffer_Sel = 1.
  - On Mem_Ready go to EXEC2.
- EXEC2: one idle cycle with all outputs 0 (bus turnaround), then FETCH.
- HALT: Halted = 1; remains until reset.
- FAULT: Halted = 1, Fault = 1; remains until reset.
- Acc_Buffer_Sel is never high in a cycle with Mem_Rd = 1 (no bus contention).
- The wait counter clears on every state change.

Test Plan:
- Reset, then release rst with Mem_Ready tied high → FETCH asserts PC_Buffer_Sel = 1, Mem_Rd = 1, IReg_En = 1; every other output is 0 during reset.
- IReg = 0x15 (LDI 5) with immediate Mem_Ready → sequence FETCH, DECODE, EXEC, FETCH; Acc_En = 1 with Mux_Acc_In_Sel = 1 in EXEC; 3 cycles per instruction.
- IReg = 0x4A (ADD), Mem_Ready delayed 3 cycles in EXEC → Mem_Rd and IReg_Buffer_Sel held for 4 cycles; Acc_En pulses once, only in the Mem_Ready cycle, with ALU_Sel = 0 and Mux_Acc_In_Sel = 3.
- IReg = 0x93 (JZ 3) → Acc_Data_Out = 0 gives PC_En = 1 and Mux_PC_Add_Sel = 0; Acc_Data_Out = 0x01 gives PC_En = 0.
- IReg = 0xB2 (STIND) → EXEC: IAR_En with IReg_Buffer_Sel; INDIR: Mem_Wr with IAR_Buffer_Sel and Acc_Buffer_Sel; EXEC2: all outputs 0; then FETCH.
- Mem_Ready never asserted in FETCH → after 15 cycles state = FAULT (6), Fault = 1, Halted = 1. Asserting rst low mid-wait instead returns to FETCH with all outputs 0 asynchronously.
